// File: rtl/aes_job_ctrl_if.sv
// SoftReg request/response bundle between the shell (master) and aes_job_ctrl (slave).
interface aes_job_ctrl_if;
    logic        softreg_req_valid;
    logic        softreg_req_isWrite;
    logic [31:0] softreg_req_addr;
    logic [63:0] softreg_req_data;
    logic        softreg_resp_valid;
    logic [63:0] softreg_resp_data;

    modport master (
        output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        input  softreg_resp_valid, softreg_resp_data
    );

    modport slave (
        input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        output softreg_resp_valid, softreg_resp_data
    );
endinterface

// File: rtl/aes_job_ctrl.sv
// SoftReg-programmed AES job sequencer: config registers, start/abort strobes, block counting, status.
// Optional cycle counter at 0x38 enabled by defining AES_JOB_PERF_EN.
module aes_job_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned KEY_W  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_job_ctrl_if.slave     sr,
    output logic [ADDR_W-1:0] cfg_src_addr,
    output logic [ADDR_W-1:0] cfg_dst_addr,
    output logic [CNT_W-1:0]  cfg_num_blocks,
    output logic [KEY_W-1:0]  cfg_key,
    output logic              dp_start,
    output logic              dp_abort,
    input  logic              dp_blk_done,
    input  logic              dp_idle
);
    localparam int unsigned DATA_W = 64;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_ABORT, S_DONE} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [CNT_W-1:0]    r_num;
    logic [DATA_W-1:0]   r_key_lo;
    logic [DATA_W-1:0]   r_key_hi;
    logic [CNT_W-1:0]    r_blocks_done;
    logic                r_done;
    logic                r_aborted;
    logic                r_dp_start;
    logic                r_dp_abort;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;

    logic                w_wr;
    logic                w_rd;
    logic [2:0]          w_sel;
    logic                w_busy;
    logic                w_idle;
    logic                w_start;
    logic                w_abort;
    logic                w_launch;
    logic                w_counting;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [DATA_W-1:0]   w_cycles_rd;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_unused;

    assign w_wr       = sr.softreg_req_valid &  sr.softreg_req_isWrite;
    assign w_rd       = sr.softreg_req_valid & ~sr.softreg_req_isWrite;
    assign w_sel      = sr.softreg_req_addr[5:3];
    assign w_busy     = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_ABORT);
    assign w_idle     = (r_state == S_IDLE);
    assign w_start    = w_wr && (w_sel == 3'd0) && sr.softreg_req_data[0];
    assign w_abort    = w_wr && (w_sel == 3'd0) && sr.softreg_req_data[1];
    assign w_launch   = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_start && (r_num != '0);
    assign w_counting = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_unused   = ^{sr.softreg_req_addr[31:6], sr.softreg_req_addr[2:0]};

    // Saturating completion count for this cycle
    always_comb begin
        w_cnt_next = r_blocks_done;
        if (w_counting && dp_blk_done && (r_blocks_done != '1))
            w_cnt_next = CNT_W'(r_blocks_done + 1'b1);
    end

`ifdef AES_JOB_PERF_EN
    logic [CNT_W-1:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (w_launch) begin
            r_cycles <= '0;
        end else if (w_counting && (r_cycles != '1)) begin
            r_cycles <= CNT_W'(r_cycles + 1'b1);
        end
    end

    assign w_cycles_rd = DATA_W'(r_cycles);
`else
    assign w_cycles_rd = '0;
`endif

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            3'd0:    w_rd_data = {60'b0, r_aborted, r_done, w_busy, w_idle};
            3'd1:    w_rd_data = DATA_W'(r_src);
            3'd2:    w_rd_data = DATA_W'(r_dst);
            3'd3:    w_rd_data = DATA_W'(r_num);
            3'd4:    w_rd_data = r_key_lo;
            3'd5:    w_rd_data = r_key_hi;
            3'd6:    w_rd_data = DATA_W'(r_blocks_done);
            default: w_rd_data = w_cycles_rd;
        endcase
    end

    // Register file, read response and job FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_src         <= '0;
            r_dst         <= '0;
            r_num         <= '0;
            r_key_lo      <= '0;
            r_key_hi      <= '0;
            r_blocks_done <= '0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_dp_start    <= 1'b0;
            r_dp_abort    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
        end else begin
            r_dp_start   <= 1'b0;
            r_dp_abort   <= 1'b0;
            r_resp_valid <= w_rd;
            if (w_rd)
                r_resp_data <= w_rd_data;

            if (w_wr && !w_busy) begin
                case (w_sel)
                    3'd1:    r_src    <= ADDR_W'(sr.softreg_req_data);
                    3'd2:    r_dst    <= ADDR_W'(sr.softreg_req_data);
                    3'd3:    r_num    <= sr.softreg_req_data[CNT_W-1:0];
                    3'd4:    r_key_lo <= sr.softreg_req_data;
                    3'd5:    r_key_hi <= sr.softreg_req_data;
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_blocks_done <= '0;
                        r_done        <= 1'b0;
                        r_aborted     <= 1'b0;
                        r_dp_start    <= 1'b1;
                        r_state       <= S_RUN;
                    end else if (w_start) begin
                        r_done    <= 1'b1;
                        r_aborted <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_RUN: begin
                    r_blocks_done <= w_cnt_next;
                    if (w_abort) begin
                        r_dp_abort <= 1'b1;
                        r_state    <= S_ABORT;
                    end else if (w_cnt_next == r_num) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_blocks_done <= w_cnt_next;
                    if (w_abort) begin
                        r_dp_abort <= 1'b1;
                        r_state    <= S_ABORT;
                    end else if (dp_idle) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_ABORT: begin
                    if (dp_idle) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_src_addr          = r_src;
    assign cfg_dst_addr          = r_dst;
    assign cfg_num_blocks        = r_num;
    assign cfg_key               = KEY_W'({r_key_hi, r_key_lo});
    assign dp_start              = r_dp_start;
    assign dp_abort              = r_dp_abort;
    assign sr.softreg_resp_valid = r_resp_valid;
    assign sr.softreg_resp_data  = r_resp_data;
endmodule

// File: tb/tb_aes_job_ctrl.sv
// Directed self-checking bench for aes_job_ctrl; define AES_JOB_PERF_EN to cover the cycle counter.
module tb_aes_job_ctrl;
    logic         clk;
    logic         rst_n;
    logic [63:0]  cfg_src_addr;
    logic [63:0]  cfg_dst_addr;
    logic [31:0]  cfg_num_blocks;
    logic [127:0] cfg_key;
    logic         dp_start;
    logic         dp_abort;
    logic         dp_blk_done;
    logic         dp_idle;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_abort = 0;

    aes_job_ctrl_if sr ();

    aes_job_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sr             (sr),
        .cfg_src_addr   (cfg_src_addr),
        .cfg_dst_addr   (cfg_dst_addr),
        .cfg_num_blocks (cfg_num_blocks),
        .cfg_key        (cfg_key),
        .dp_start       (dp_start),
        .dp_abort       (dp_abort),
        .dp_blk_done    (dp_blk_done),
        .dp_idle        (dp_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dp_start === 1'b1) n_start++;
        if (dp_abort === 1'b1) n_abort++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sr_write(input logic [31:0] addr, input logic [63:0] data);
        sr.softreg_req_valid   = 1'b1;
        sr.softreg_req_isWrite = 1'b1;
        sr.softreg_req_addr    = addr;
        sr.softreg_req_data    = data;
        tick();
        sr.softreg_req_valid   = 1'b0;
        sr.softreg_req_isWrite = 1'b0;
    endtask

    task automatic sr_read(input string tag, input logic [31:0] addr, input logic [63:0] exp);
        sr.softreg_req_valid   = 1'b1;
        sr.softreg_req_isWrite = 1'b0;
        sr.softreg_req_addr    = addr;
        tick();
        sr.softreg_req_valid   = 1'b0;
        check({tag, "_valid"}, 128'(sr.softreg_resp_valid), 128'(1));
        check(tag, 128'(sr.softreg_resp_data), 128'(exp));
    endtask

    task automatic blk_pulse();
        dp_blk_done = 1'b1;
        tick();
        dp_blk_done = 1'b0;
        tick();
    endtask

    initial begin
        rst_n                  = 1'b0;
        dp_blk_done            = 1'b0;
        dp_idle                = 1'b0;
        sr.softreg_req_valid   = 1'b0;
        sr.softreg_req_isWrite = 1'b0;
        sr.softreg_req_addr    = '0;
        sr.softreg_req_data    = '0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state and first read
        check("rst_src", 128'(cfg_src_addr), 128'(0));
        check("rst_dst", 128'(cfg_dst_addr), 128'(0));
        check("rst_num", 128'(cfg_num_blocks), 128'(0));
        check("rst_key", cfg_key, 128'(0));
        check("rst_resp_valid", 128'(sr.softreg_resp_valid), 128'(0));
        sr_read("rst_status", 32'h00, 64'h1);
        tick();
        check("resp_one_cycle", 128'(sr.softreg_resp_valid), 128'(0));

        // Normal 4-block job
        sr_write(32'h08, 64'h1000);
        check("write_no_resp", 128'(sr.softreg_resp_valid), 128'(0));
        sr_write(32'h10, 64'h2000);
        sr_write(32'h18, 64'h4);
        sr_write(32'h20, 64'h1111_2222_3333_4444);
        sr_write(32'h28, 64'h5555_6666_7777_8888);
        check("cfg_src", 128'(cfg_src_addr), 128'h1000);
        check("cfg_dst", 128'(cfg_dst_addr), 128'h2000);
        check("cfg_num", 128'(cfg_num_blocks), 128'h4);
        check("cfg_key", cfg_key, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
        sr_write(32'h00, 64'h1);
        check("dp_start_hi", 128'(dp_start), 128'(1));
        tick();
        check("dp_start_lo", 128'(dp_start), 128'(0));
        sr_read("run_status", 32'h00, 64'h2);
        for (int i = 0; i < 4; i++) blk_pulse();
        sr_read("drain_status", 32'h00, 64'h2);
        dp_idle = 1'b1;
        tick();
        dp_idle = 1'b0;
        sr_read("done_status", 32'h00, 64'h4);
        sr_read("blocks_done4", 32'h30, 64'h4);
        check("start_count1", 128'(n_start), 128'(1));

        // Zero-length job completes without dp_start
        sr_write(32'h18, 64'h0);
        sr_write(32'h00, 64'h1);
        check("zero_no_start", 128'(dp_start), 128'(0));
        sr_read("zero_status", 32'h00, 64'h4);
        check("start_count_zero", 128'(n_start), 128'(1));

        // Abort mid-job, with config lockout and ignored restart
        sr_write(32'h18, 64'h8);
        sr_write(32'h00, 64'h1);
        tick();
        for (int i = 0; i < 3; i++) blk_pulse();
        sr_write(32'h08, 64'hdead);
        sr_read("src_locked", 32'h08, 64'h1000);
        sr_write(32'h00, 64'h1);
        tick();
        check("restart_ignored", 128'(n_start), 128'(2));
        sr_write(32'h00, 64'h2);
        check("dp_abort_hi", 128'(dp_abort), 128'(1));
        tick();
        check("dp_abort_lo", 128'(dp_abort), 128'(0));
        for (int i = 0; i < 5; i++) tick();
        sr_read("abort_wait_status", 32'h00, 64'h2);
        dp_idle = 1'b1;
        tick();
        dp_idle = 1'b0;
        sr_read("aborted_status", 32'h00, 64'h9);
        sr_read("blocks_done3", 32'h30, 64'h3);
        check("abort_count1", 128'(n_abort), 128'(1));

        // Ignored events in IDLE; read-only write ignored
        blk_pulse();
        sr_write(32'h30, 64'h77);
        sr_read("idle_blk_ignored", 32'h30, 64'h3);
        sr_write(32'h00, 64'h2);
        check("idle_abort_ignored", 128'(dp_abort), 128'(0));
        sr_read("idle_abort_status", 32'h00, 64'h9);

        // Start+abort together: start when idle, abort when busy
        sr_write(32'h00, 64'h3);
        check("both_idle_start", 128'(dp_start), 128'(1));
        tick();
        sr_write(32'h00, 64'h3);
        check("both_busy_abort", 128'(dp_abort), 128'(1));
        dp_idle = 1'b1;
        tick();
        dp_idle = 1'b0;
        sr_read("both_status", 32'h00, 64'h9);
        sr_read("both_blocks_cleared", 32'h30, 64'h0);

        // Two-block job with known cycle count
        sr_write(32'h18, 64'h2);
        sr_write(32'h00, 64'h1);
        tick();
        tick();
        dp_blk_done = 1'b1; tick(); dp_blk_done = 1'b0;
        tick();
        dp_blk_done = 1'b1; tick(); dp_blk_done = 1'b0;
        tick();
        dp_idle = 1'b1; tick(); dp_idle = 1'b0;
        sr_read("perf_status", 32'h00, 64'h4);
        sr_read("perf_blocks", 32'h30, 64'h2);
`ifdef AES_JOB_PERF_EN
        sr_read("cycles", 32'h38, 64'h7);
`else
        sr_read("cycles_absent", 32'h38, 64'h0);
`endif

        // Asynchronous reset mid-RUN
        sr_write(32'h18, 64'h5);
        sr_write(32'h00, 64'h1);
        check("pre_rst_start", 128'(dp_start), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dp_start", 128'(dp_start), 128'(0));
        check("arst_src", 128'(cfg_src_addr), 128'(0));
        check("arst_num", 128'(cfg_num_blocks), 128'(0));
        check("arst_key", cfg_key, 128'(0));
        check("arst_resp_data", 128'(sr.softreg_resp_data), 128'(0));
        rst_n = 1'b1;
        tick();
        sr_read("post_rst_status", 32'h00, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_job_ctrl.md
Name: aes_job_ctrl

Overview:
Soft-register-programmed job sequencer for the AES datapath. Host software writes job configuration (source and destination buffers, block count, key) over the SoftReg interface, then starts a job. The block drives the datapath's config and start/abort strobes, counts completed 128-bit blocks, and reports status. It sits between the shell SoftReg port and the AES engine inside the AES wrapper.

Parameters:
ADDR_W, 64, width of source/destination virtual addresses
CNT_W, 32, width of block count and completion counter
KEY_W, 128, AES key width, stored as two 64-bit registers

Ports:
clk  in  1  user clock
rst_n  in  1  asynchronous active-low reset
softreg_req_valid  in  1  SoftReg request strobe
softreg_req_isWrite  in  1  1 = write, 0 = read
softreg_req_addr  in  32  byte address; bits [5:3] select register
softreg_req_data  in  64  write data
softreg_resp_valid  out  1  read response strobe
softreg_resp_data  out  64  read response data
cfg_src_addr  out  ADDR_W  source buffer base address
cfg_dst_addr  out  ADDR_W  destination buffer base address
cfg_num_blocks  out  CNT_W  number of 16-byte blocks in the job
cfg_key  out  KEY_W  cipher key
dp_start  out  1  one-cycle job start pulse
dp_abort  out  1  one-cycle abort pulse
dp_blk_done  in  1  one pulse per block written back
dp_idle  in  1  datapath has no outstanding AXI traffic

Behaviour:
- Register map, 8-byte stride:
  - 0x00 CTRL/STATUS. Write bit0 = start, bit1 = abort. Read returns {60'b0, aborted, done, busy, state==IDLE}.
  - 0x08 SRC, 0x10 DST, 0x18 NUM_BLOCKS (low CNT_W bits), 0x20 KEY_LO, 0x28 KEY_HI.
  - 0x30 BLOCKS_DONE (read-only).
  - 0x38 CYCLES (read-only, optional feature).
- Config registers drive the cfg_* outputs directly.
- Writes to 0x08–0x28 are ignored while busy (state RUN, DRAIN or ABORT). Writes to read-only addresses are ignored.
- Reads: softreg_resp_valid asserts exactly 1 cycle after an accepted read, with registered data. Writes produce no response. Back-to-back reads yield back-to-back responses.
- FSM states: IDLE, RUN, DRAIN, ABORT, DONE.
  - IDLE/DONE + start, num_blocks != 0: clear BLOCKS_DONE, aborted and done; dp_start=1 for 1 cycle; go to RUN.
  - IDLE/DONE + start, num_blocks == 0: go to DONE with done=1. No dp_start pulse.
  - RUN: each dp_blk_done increments BLOCKS_DONE. When the counter reaches num_blocks (including on the incrementing cycle), go to DRAIN.
  - DRAIN: wait for dp_idle=1, then go to DONE with done=1.
  - RUN/DRAIN + abort: dp_abort=1 for 1 cycle; go to ABORT.
  - ABORT: wait for dp_idle, then go to IDLE with aborted=1.
- Start while busy is ignored. Abort in IDLE/DONE is ignored.
- CTRL write with start and abort both set: abort wins if busy; otherwise start is taken.
- BLOCKS_DONE saturates at 2^CNT_W-1. dp_blk_done outside RUN/DRAIN is ignored.
- Reset (asynchronous, any state): state=IDLE. All config registers, counters and flags = 0. softreg_resp_valid=0, softreg_resp_data=0, dp_start=0, dp_abort=0.

Optional Feature:
AES_JOB_PERF_EN.
- Defined: a CNT_W-bit CYCLES counter clears on dp_start and increments each cycle in RUN or DRAIN. It saturates and holds its value after DONE or ABORT. Readable at 0x38.
- Undefined: no counter logic; reads of 0x38 return 0.

Test Plan:
1. Reset, then read 0x00 -> resp 1 cycle later, data 0x1. All cfg_* = 0.
2. Write SRC=0x1000, DST=0x2000, NUM=4, start. Pulse dp_blk_done 4 times, then dp_idle=1 -> dp_start single pulse. STATUS reads busy during job, then 0x4 (done). BLOCKS_DONE=4.
3. Start with NUM=0 -> no dp_start; STATUS=done (0x4) next cycle.
4. NUM=8, start, 3 blk_done, abort with dp_idle held 0 for 5 cycles -> dp_abort single pulse. State holds ABORT until dp_idle, then STATUS=0x9 (aborted, idle). BLOCKS_DONE=3.
5. Mid-job write SRC=0xdead -> SRC readback unchanged. Second start ignored; only one dp_start seen.
6. Deassert rst_n asynchronously mid-RUN -> outputs zero immediately. With AES_JOB_PERF_EN, a NUM=2 job with blk_done at cycles 3 and 5 and dp_idle at cycle 7 -> CYCLES=7.
